mdu_ctrl: RTL and testbench

Iterative multiply/divide controller for the pipelined MIPS core. It owns the HI/LO registers and sequences a radix-2 shift-add / shift-subtract datapath for MULT, MULTU, DIV and DIVU. It also executes MTHI and MTLO. It sits beside the EX-stage ALU and raises `busy` so the hazard unit can stall MFHI, MFLO and any new MDU operation until HI/LO are final.

---
 rtl/mdu_ctrl_pkg.sv | 35 +++
 rtl/mdu_ctrl_step.sv | 31 +++
 rtl/mdu_ctrl.sv | 139 +++++++++++++
 tb/tb_mdu_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states and
// the default iteration count.
package mdu_defs;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // one radix-2 step per operand bit
  localparam int MDU_STEPS = 32;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_iter(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_step.sv
// Single radix-2 iteration: shift-add for multiply, restoring
// shift-subtract for divide. Purely combinational.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum    = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // remainder after the left shift needs one extra bit before the trial subtract
    rem_sh = acc_in[2*WIDTH-1:WIDTH-1];
    ge     = (rem_sh >= {1'b0, opnd});
    diff   = rem_sh[WIDTH-1:0] - opnd;
    if (is_div) begin
      if (ge) acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
      else    acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide controller owning HI/LO. Operands are reduced to
// magnitudes on issue; the sign is restored in FIX before the commit.
//
// state   | meaning
// IDLE    | accepts start; MTHI/MTLO/divide-by-zero complete here
// CALC    | WIDTH iteration steps, cnt = 0..WIDTH-1
// FIX     | sign correction, HI/LO commit on the exiting edge
module mdu_ctrl
  import mdu_defs::*;
#(
  parameter int WIDTH = MDU_STEPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e state, state_nx;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     opnd;
  logic                 is_div;
  logic                 neg_res;
  logic                 neg_rem;

  logic                 idle;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 launch, div_zero, mthi, mtlo, commit;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  // issue decode
  always_comb begin
    idle     = (state == ST_IDLE);
    a_neg    = op_is_signed(op) & a[WIDTH-1];
    b_neg    = op_is_signed(op) & b[WIDTH-1];
    // -(most negative) wraps back to 2^(W-1), which is the correct unsigned magnitude
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = idle & start & op_is_div(op) & (b == '0);
    launch   = idle & start & op_is_iter(op) & ~div_zero;
    mthi     = idle & start & (op == OP_MTHI);
    mtlo     = idle & start & (op == OP_MTLO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (launch) state_nx = ST_CALC;
      ST_CALC: begin
        if (cancel)           state_nx = ST_IDLE;
        else if (cnt == LAST) state_nx = ST_FIX;
      end
      ST_FIX:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != ST_IDLE);
    commit = (state == ST_FIX) & ~cancel;
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_in  (acc),
    .opnd    (opnd),
    .acc_out (acc_step)
  );

  // multiply: acc = {partial, multiplier}; divide: acc = {rem, dividend/quot}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      opnd    <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (launch) begin
      acc     <= op_is_div(op) ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      opnd    <= op_is_div(op) ? b_mag : a_mag;
      cnt     <= '0;
      is_div  <= op_is_div(op);
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
    end else if ((state == ST_CALC) && !cancel) begin
      acc <= acc_step;
      if (cnt != LAST) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (div_zero) begin
      hi <= a;
      lo <= '1;
    end else if (mthi) begin
      hi <= a;
    end else if (mtlo) begin
      lo <= a;
    end else if (commit) begin
      if (is_div) begin
        hi <= rem_fix;
        lo <= quot_fix;
      end else begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: an arithmetic reference model with a countdown for the
// busy window, checked every cycle, plus literal checks of known results.
module tb_mdu_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference arithmetic, returns {hi, lo}
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint       sp, sq, sr;
    logic [63:0]  up;
    logic [31:0]  uq, ur;
    ref_result = '0;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        ref_result = sp;
      end
      3'd1: begin
        up = 64'(x) * 64'(y);
        ref_result = up;
      end
      3'd2: begin
        sq = longint'($signed(x)) / longint'($signed(y));
        sr = longint'($signed(x)) % longint'($signed(y));
        ref_result = {sr[31:0], sq[31:0]};
      end
      3'd3: begin
        uq = x / y;
        ur = x % y;
        ref_result = {ur, uq};
      end
      default: ref_result = '0;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi   <= '0;
      m_lo   <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      m_left <= 0;
    end else if (m_left == 0) begin
      if (start) begin
        case (op)
          3'd4: m_hi <= a;
          3'd5: m_lo <= a;
          3'd0, 3'd1: begin
            {p_hi, p_lo} <= ref_result(op, a, b);
            m_left       <= W + 1;
          end
          3'd2, 3'd3: begin
            if (b == 0) begin
              m_hi <= a;
              m_lo <= '1;
            end else begin
              {p_hi, p_lo} <= ref_result(op, a, b);
              m_left       <= W + 1;
            end
          end
          default: ;
        endcase
      end
    end else if (cancel) begin
      m_left <= 0;
    end else if (m_left == 1) begin
      m_hi   <= p_hi;
      m_lo   <= p_lo;
      m_left <= 0;
    end else begin
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_vs_model", {31'b0, busy}, {31'b0, (m_left != 0)});
      check("hi_vs_model", hi, m_hi);
      check("lo_vs_model", lo, m_lo);
    end
  end

  // called at a negedge; returns at the first negedge with busy low
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit inject, output int ncyc);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    ncyc  = 0;
    while (busy && ncyc < 40) begin
      ncyc++;
      if (inject && ncyc == 5) begin
        start = 1'b1;
        op    = 3'd3;
        a     = 32'd100;
        b     = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (ncyc >= 40) begin
      tests++;
      fails++;
      $display("FAIL busy_timeout: busy still high after %0d cycles, required low", ncyc);
    end
  endtask

  // cancel on the k-th busy cycle of a MULT 6x7
  task automatic run_cancel(input int k, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1;
    op    = 3'd0;
    a     = 32'd6;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (k - 1) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", {31'b0, busy}, 32'd0);
    check("cancel_hi", hi, exp_hi);
    check("cancel_lo", lo, exp_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, n);
    check("multu_busy_cycles", n, 32'd33);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    do_op(3'd0, 32'hFFFFFFFD, 32'd5, 1'b1, n);
    check("mult_neg_cycles", n, 32'd33);
    check("mult_neg_hi", hi, 32'hFFFFFFFF);
    check("mult_neg_lo", lo, 32'hFFFFFFF1);

    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, n);
    check("div_neg_hi", hi, 32'hFFFFFFFF);
    check("div_neg_lo", lo, 32'hFFFFFFFD);

    do_op(3'd3, 32'd100, 32'd7, 1'b0, n);
    check("divu_hi", hi, 32'd2);
    check("divu_lo", lo, 32'd14);

    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, n);
    check("div_minneg_hi", hi, 32'd0);
    check("div_minneg_lo", lo, 32'h80000000);

    do_op(3'd3, 32'h1234, 32'd0, 1'b0, n);
    check("divz_cycles", n, 32'd0);
    check("divz_hi", hi, 32'h1234);
    check("divz_lo", lo, 32'hFFFFFFFF);

    do_op(3'd4, 32'hABCD, 32'd0, 1'b0, n);
    check("mthi_cycles", n, 32'd0);
    check("mthi_hi", hi, 32'hABCD);
    check("mthi_lo_kept", lo, 32'hFFFFFFFF);

    do_op(3'd0, 32'h7FFFFFFF, 32'h80000000, 1'b0, n);
    do_op(3'd2, 32'd7, 32'hFFFFFFFE, 1'b0, n);
    do_op(3'd3, 32'd5, 32'd9, 1'b0, n);
    do_op(3'd1, 32'd0, 32'hDEADBEEF, 1'b0, n);
    do_op(3'd2, 32'h80000000, 32'h80000000, 1'b0, n);

    do_op(3'd4, 32'd1, 32'd0, 1'b0, n);
    do_op(3'd5, 32'd2, 32'd0, 1'b0, n);
    run_cancel(10, 32'd1, 32'd2);
    run_cancel(33, 32'd1, 32'd2);
    do_op(3'd0, 32'd6, 32'd7, 1'b0, n);
    check("mult_after_cancel_hi", hi, 32'd0);
    check("mult_after_cancel_lo", lo, 32'd42);

    start = 1'b1;
    op    = 3'd0;
    a     = 32'd6;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(3'd3, 32'd9, 32'd3, 1'b0, n);
    check("divu_after_rst_hi", hi, 32'd0);
    check("divu_after_rst_lo", lo, 32'd3);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
